// File: rtl/noc_params.sv
// Shared NoC router parameters and the output-port encoding used across the router.
package noc_params;

  localparam int unsigned PORT_NUM = 5;
  localparam int unsigned VC_NUM   = 2;
  localparam int unsigned VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

endpackage

// File: rtl/switch_allocator_rr.sv
// Round-robin arbiter: one-hot grant searched upward from an internal pointer,
// pointer advances past the winner only when the caller confirms with update_i.
module round_robin_arbiter #(
  parameter int unsigned AGENTS_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AGENTS_NUM-1:0] requests_i,
  input  logic                  update_i,
  output logic [AGENTS_NUM-1:0] grant_o
);

  localparam int unsigned PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] win;
  logic             found;
  int unsigned      idx;

  always_comb begin : search
    grant_o = '0;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < AGENTS_NUM; i++) begin
      idx = (32'(ptr_q) + i) % AGENTS_NUM;
      if (!found && requests_i[PTR_W'(idx)]) begin
        grant_o[PTR_W'(idx)] = 1'b1;
        win                  = PTR_W'(idx);
        found                = 1'b1;
      end
    end
  end

  // Kept apart from the search so update_i never feeds back into the grant path.
  always_comb begin : next_ptr
    ptr_d = ptr_q;
    if (update_i && found) begin
      ptr_d = (win == PTR_W'(AGENTS_NUM - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration, then per-output
// input arbitration; grants are combinational so buffers are read in the same cycle.
module switch_allocator
  import noc_params::port_t;
  import noc_params::VC_SIZE;
#(
  parameter int unsigned PORT_NUM = noc_params::PORT_NUM,
  parameter int unsigned VC_NUM   = noc_params::VC_NUM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               request_i       [PORT_NUM][VC_NUM],
  input  port_t              out_port_i      [PORT_NUM][VC_NUM],
  input  logic [VC_SIZE-1:0] downstream_vc_i [PORT_NUM][VC_NUM],
  input  logic               on_off_i        [PORT_NUM][VC_NUM],
  output logic               valid_sel_o     [PORT_NUM],
  output logic [VC_SIZE-1:0] vc_sel_o        [PORT_NUM],
  output logic               valid_flit_o    [PORT_NUM],
  output port_t              xb_sel_o        [PORT_NUM],
  output logic [VC_SIZE-1:0] downstream_vc_o [PORT_NUM]
);

  localparam int unsigned PSEL_W = $bits(port_t);

  logic [VC_NUM-1:0]   req1     [PORT_NUM];
  logic [VC_NUM-1:0]   grant1   [PORT_NUM];
  logic [PORT_NUM-1:0] req2     [PORT_NUM];
  logic [PORT_NUM-1:0] grant2   [PORT_NUM];
  logic                s1_valid [PORT_NUM];
  logic [VC_SIZE-1:0]  s1_vc    [PORT_NUM];
  port_t               s1_out   [PORT_NUM];
  logic [VC_SIZE-1:0]  s1_dvc   [PORT_NUM];
  logic [PORT_NUM-1:0] in_win;

  // A VC is eligible only if its downstream VC on the routed output has space.
  always_comb begin : eligibility
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      req1[p] = '0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        req1[p][v] = request_i[p][v]
                   && (32'(out_port_i[p][v]) < PORT_NUM)
                   && on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]];
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in_arb
    round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .requests_i (req1[p]),
      .update_i   (in_win[p]),
      .grant_o    (grant1[p])
    );
  end

  always_comb begin : stage1_decode
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      s1_valid[p] = |grant1[p];
      s1_vc[p]    = '0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (grant1[p][v]) s1_vc[p] = VC_SIZE'(v);
      end
      s1_out[p] = out_port_i[p][s1_vc[p]];
      s1_dvc[p] = downstream_vc_i[p][s1_vc[p]];
    end
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      req2[o] = '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        req2[o][p] = s1_valid[p] && (32'(s1_out[p]) == o);
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
    round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .requests_i (req2[o]),
      .update_i   (1'b1),
      .grant_o    (grant2[o])
    );
  end

  // Outputs held at zero throughout reset regardless of requests.
  always_comb begin : drive_outputs
    in_win = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      valid_sel_o[i]     = 1'b0;
      vc_sel_o[i]        = '0;
      valid_flit_o[i]    = 1'b0;
      xb_sel_o[i]        = port_t'(PSEL_W'(0));
      downstream_vc_o[i] = '0;
    end
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (!rst && grant2[o][p]) begin
          valid_flit_o[o]    = 1'b1;
          xb_sel_o[o]        = port_t'(PSEL_W'(p));
          downstream_vc_o[o] = s1_dvc[p];
          valid_sel_o[p]     = 1'b1;
          vc_sel_o[p]        = s1_vc[p];
          in_win[p]          = 1'b1;
        end
      end
    end
  end

endmodule
